conv_encoder_framed: RTL and testbench

//  Parametrised rate-1/N_OUT feed-forward convolutional encoder with framing.
//  Two run-time selectable codes (A/B) with independent constraint lengths and generators.

---
 rtl/conv_encoder_framed.sv | 89 ++++++++
 tb/tb_conv_encoder_framed.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_framed.sv
// conv_encoder_framed: framed rate-1/N_OUT feed-forward convolutional encoder
// with two selectable codes, valid/ready handshakes and automatic zero-tail termination.
module conv_encoder_framed #(
   parameter int N_OUT = 2,
   parameter int K_MAX = 7,
   parameter int K_A   = 3,
   parameter int K_B   = 7,
   parameter logic [N_OUT*K_MAX-1:0] G_A = {7'o005, 7'o007},
   parameter logic [N_OUT*K_MAX-1:0] G_B = {7'o155, 7'o117}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             choose_constraint_length,
   input  logic             unencoded_bits,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [N_OUT-1:0] out,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy
);
   localparam int CW = $clog2(K_MAX + 1);
   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
   state_t state_q, state_d;
   logic mode_q, mode_d;
   logic [CW-1:0] tail_cnt_q, tail_cnt_d, k_n;
   logic [K_MAX-1:0] sr_q, sr_d, taps, mask;
   logic [N_OUT*K_MAX-1:0] g;
   logic [N_OUT-1:0] out_q, out_d, sym;
   logic out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic adv, acc, tail_step, fin, step;
   always_comb begin
      adv = !out_valid_q || out_ready;
      in_ready = adv && (state_q != TAIL);
      acc = in_valid && in_ready;
      tail_step = adv && (state_q == TAIL);
      fin = tail_step && (tail_cnt_q == CW'(1));
      step = acc || tail_step;
      // the code is sampled only on the first beat of a frame
      mode_d = (state_q == IDLE && acc) ? choose_constraint_length : mode_q;
      k_n = mode_d ? CW'(K_B) : CW'(K_A);
      g = mode_d ? G_B : G_A;
      taps = {sr_q[K_MAX-2:0], unencoded_bits && (state_q != TAIL)};
      for (int i = 0; i < K_MAX; i++) mask[i] = CW'(i) < k_n;
      for (int j = 0; j < N_OUT; j++) sym[j] = ^(taps & mask & g[j*K_MAX +: K_MAX]);
      // clearing on the final tail step also flushes taps beyond a short code's span
      sr_d = fin ? '0 : step ? taps : sr_q;
      out_d = step ? sym : out_q;
      out_valid_d = step ? 1'b1 : adv ? 1'b0 : out_valid_q;
      out_last_d = step ? fin : adv ? 1'b0 : out_last_q;
      state_d = state_q;
      tail_cnt_d = tail_cnt_q;
      if (acc && in_last) begin
         state_d = TAIL;
         tail_cnt_d = k_n - CW'(1);
      end else if (acc && state_q == IDLE) begin
         state_d = DATA;
      end
      if (tail_step) begin
         tail_cnt_d = tail_cnt_q - CW'(1);
         state_d = fin ? IDLE : TAIL;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q <= 1'b0;
         tail_cnt_q <= '0;
         sr_q <= '0;
         out_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q <= mode_d;
         tail_cnt_q <= tail_cnt_d;
         sr_q <= sr_d;
         out_q <= out_d;
         out_valid_q <= out_valid_d;
         out_last_q <= out_last_d;
      end
   end
   assign out = out_q;
   assign out_valid = out_valid_q;
   assign out_last = out_last_q;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_conv_encoder_framed.sv
// tb_conv_encoder_framed: scoreboard bench for conv_encoder_framed with default
// parameters (code A K=3 gens 7/5, code B K=7 gens 117/155 octal).
module tb_conv_encoder_framed;
   logic clk = 1'b0, rst_n = 1'b0;
   logic choose_constraint_length = 1'b0, unencoded_bits = 1'b0, in_valid = 1'b0, in_last = 1'b0;
   logic out_ready = 1'b1;
   logic in_ready, out_valid, out_last, busy;
   logic [1:0] out;
   int total = 0, bad = 0, stall_cnt = 0;
   logic [2:0] sb[$];
   logic stall_prev = 1'b0;
   logic [3:0] held;
   localparam logic [13:0] GA = {7'o005, 7'o007};
   localparam logic [13:0] GB = {7'o155, 7'o117};

   conv_encoder_framed dut (
      .clk(clk), .rst_n(rst_n), .choose_constraint_length(choose_constraint_length),
      .unencoded_bits(unencoded_bits), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   function automatic logic [1:0] enc(input logic [6:0] t, input logic m);
      logic [13:0] g;
      logic [1:0] r;
      int k;
      g = m ? GB : GA;
      k = m ? 7 : 3;
      r = '0;
      for (int j = 0; j < 2; j++)
         for (int i = 0; i < k; i++) r[j] = r[j] ^ (g[j*7+i] & t[i]);
      return r;
   endfunction

   task automatic push_model(input logic m, input int n, input logic [31:0] bits);
      logic [6:0] s;
      int k;
      s = '0;
      k = m ? 7 : 3;
      for (int b = 0; b < n; b++) begin
         s = {s[5:0], bits[b]};
         sb.push_back({1'b0, enc(s, m)});
      end
      for (int t = 1; t < k; t++) begin
         s = {s[5:0], 1'b0};
         sb.push_back({t == k - 1, enc(s, m)});
      end
   endtask

   task automatic send_frame(input logic m, input int n, input logic [31:0] bits, input bit tog);
      for (int b = 0; b < n; b++) begin
         bit hs;
         int t;
         hs = 1'b0;
         t = 0;
         in_valid = 1'b1;
         unencoded_bits = bits[b];
         in_last = (b == n - 1);
         choose_constraint_length = (b == 0 || !tog) ? m : ~m;
         while (!hs && t < 100) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            t++;
         end
         if (!hs) chk("beat_accept_timeout", 32'd0, 32'd1);
      end
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk({nm, "_drained"}, sb.size(), 0);
      chk({nm, "_busy_idle"}, busy, 1'b0);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) chk("stall_hold", {out_valid, out_last, out}, held);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_symbol", {out_last, out}, 3'b111 ^ {out_last, out});
            else chk("symbol", {out_last, out}, sb.pop_front());
         end
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 1'b0);
            stall_cnt <= stall_cnt + 1;
            held <= {out_valid, out_last, out};
            stall_prev <= 1'b1;
         end else begin
            stall_prev <= 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out", out, 2'b00);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // code A, bits 1,0,1,1
      sb.push_back(3'b011); sb.push_back(3'b001); sb.push_back(3'b000);
      sb.push_back(3'b010); sb.push_back(3'b010); sb.push_back(3'b111);
      send_frame(1'b0, 4, 32'b1101, 1'b0);
      drain("codeA");
      // code B impulse
      sb.push_back(3'b011); sb.push_back(3'b001); sb.push_back(3'b011); sb.push_back(3'b011);
      sb.push_back(3'b000); sb.push_back(3'b010); sb.push_back(3'b111);
      send_frame(1'b1, 1, 32'b1, 1'b0);
      drain("codeB_impulse");
      // back-pressure mid-frame
      stall_cnt = 0;
      push_model(1'b0, 6, 32'b101101);
      fork
         send_frame(1'b0, 6, 32'b101101, 1'b0);
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain("backpressure");
      chk("stall_seen", stall_cnt >= 3, 1'b1);
      // mode toggled mid-frame, then new mode
      push_model(1'b0, 5, 32'b10011);
      send_frame(1'b0, 5, 32'b10011, 1'b1);
      push_model(1'b1, 3, 32'b101);
      send_frame(1'b1, 3, 32'b101, 1'b0);
      drain("mode_toggle");
      // back-to-back frames with in_valid held high
      push_model(1'b0, 4, 32'b0110);
      push_model(1'b1, 3, 32'b111);
      push_model(1'b0, 2, 32'b10);
      send_frame(1'b0, 4, 32'b0110, 1'b0);
      send_frame(1'b1, 3, 32'b111, 1'b0);
      send_frame(1'b0, 2, 32'b10, 1'b0);
      drain("back_to_back");
      // async reset in the middle of a code B tail
      push_model(1'b1, 2, 32'b11);
      send_frame(1'b1, 2, 32'b11, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", out_valid, 1'b0);
      chk("midreset_out", out, 2'b00);
      chk("midreset_out_last", out_last, 1'b0);
      chk("midreset_busy", busy, 1'b0);
      sb.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      push_model(1'b0, 3, 32'b011);
      send_frame(1'b0, 3, 32'b011, 1'b0);
      drain("after_reset");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
